// File: rtl/scytale_codec_if.sv
// Handshake bundle for the scytale codec: character input with rod keys,
// registered character output with backpressure, plus status flags.
interface scytale_codec_if #(
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic                 mode_i;
  logic [KEY_WIDTH-1:0] key_N;
  logic [KEY_WIDTH-1:0] key_M;
  logic                 ready_i;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 busy;
  logic                 err_o;

  modport master (
    output data_i, valid_i, mode_i, key_N, key_M, ready_i,
    input  data_o, valid_o, busy, err_o
  );

  modport slave (
    input  data_i, valid_i, mode_i, key_N, key_M, ready_i,
    output data_o, valid_o, busy, err_o
  );
endinterface

// File: rtl/scytale_codec.sv
// Scytale transposition codec: buffers a message until the start token, then
// streams it back in rod order (decrypt column-major, encrypt row-major).
module scytale_codec #(
  parameter int unsigned        D_WIDTH       = 8,
  parameter int unsigned        KEY_WIDTH     = 8,
  parameter int unsigned        MAX_NOF_CHARS = 64,
  parameter logic [D_WIDTH-1:0] START_TOKEN   = D_WIDTH'(8'hFA)
) (
  input  logic           clk,
  input  logic           rst_n,
  scytale_codec_if.slave bus
);
  localparam int unsigned AddrW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int unsigned CntW  = $clog2(MAX_NOF_CHARS + 1);
  localparam int unsigned ProdW = 2 * KEY_WIDTH;

  typedef enum logic [1:0] {StIdle, StEmit, StErr} state_e;

  state_e               state_q;
  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];
  logic [CntW-1:0]      cnt_q;
  logic                 ovf_q;
  logic                 mode_q;
  logic [KEY_WIDTH-1:0] n_q, m_q;
  logic [KEY_WIDTH-1:0] inner_q, outer_q;
  logic [AddrW-1:0]     idx_q, base_q;
  logic [D_WIDTH-1:0]   data_q;
  logic                 valid_q, busy_q, err_q;

  logic [ProdW-1:0]     prod;
  logic                 key_bad, store_en, inner_wrap, outer_wrap;
  logic [KEY_WIDTH-1:0] inner_lim, outer_lim, step;
  logic [AddrW-1:0]     idx_nxt, base_nxt;

  assign prod = {{KEY_WIDTH{1'b0}}, bus.key_N} * {{KEY_WIDTH{1'b0}}, bus.key_M};

  always_comb begin
    key_bad = (bus.key_N == '0) || (bus.key_M == '0) ||
              (32'(prod) > MAX_NOF_CHARS) || (32'(cnt_q) != 32'(prod)) || ovf_q;
  end

  assign store_en = (state_q == StIdle) && bus.valid_i && (bus.data_i != START_TOKEN) &&
                    (cnt_q != CntW'(MAX_NOF_CHARS));

  // Inner loop strides by the step; outer loop restarts one slot further along.
  assign inner_lim  = mode_q ? n_q : m_q;
  assign outer_lim  = mode_q ? m_q : n_q;
  assign step       = mode_q ? m_q : n_q;
  assign inner_wrap = (inner_q == inner_lim - KEY_WIDTH'(1));
  assign outer_wrap = (outer_q == outer_lim - KEY_WIDTH'(1));
  assign idx_nxt    = AddrW'(32'(idx_q) + 32'(step));
  assign base_nxt   = base_q + AddrW'(1);

  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[cnt_q[AddrW-1:0]] <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      n_q     <= '0;
      m_q     <= '0;
      inner_q <= '0;
      outer_q <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.valid_i) begin
            if (bus.data_i == START_TOKEN) begin
              mode_q  <= bus.mode_i;
              n_q     <= bus.key_N;
              m_q     <= bus.key_M;
              inner_q <= '0;
              outer_q <= '0;
              idx_q   <= '0;
              base_q  <= '0;
              if (key_bad) begin
                state_q <= StErr;
                err_q   <= 1'b1;
              end else begin
                state_q <= StEmit;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
                data_q  <= mem_q[{AddrW{1'b0}}];
              end
            end else if (cnt_q == CntW'(MAX_NOF_CHARS)) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StErr: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
        end
        StEmit: begin
          if (valid_q && bus.ready_i) begin
            if (inner_wrap && outer_wrap) begin
              state_q <= StIdle;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              data_q  <= '0;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
            end else if (inner_wrap) begin
              inner_q <= '0;
              outer_q <= outer_q + KEY_WIDTH'(1);
              base_q  <= base_nxt;
              idx_q   <= base_nxt;
              data_q  <= mem_q[base_nxt];
            end else begin
              inner_q <= inner_q + KEY_WIDTH'(1);
              idx_q   <= idx_nxt;
              data_q  <= mem_q[idx_nxt];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.busy    = busy_q;
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_scytale_codec.sv
// Scoreboard bench for scytale_codec: expected characters come from a rod
// index model and are popped as the DUT hands them over.
module tb_scytale_codec;
  localparam int unsigned DW   = 8;
  localparam int unsigned KW   = 8;
  localparam int unsigned MAXC = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scytale_codec_if #(.D_WIDTH(DW), .KEY_WIDTH(KW)) bus_if ();

  scytale_codec #(
    .D_WIDTH      (DW),
    .KEY_WIDTH    (KW),
    .MAX_NOF_CHARS(MAXC),
    .START_TOKEN  (8'hFA)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int xfer_cnt = 0;
  logic [7:0] exp_q[$];
  bit bp_en = 0;
  int ph = 0;
  bit stall_prev = 0;
  logic [7:0] prev_d = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ready_i pattern 1,0,0 when backpressure is enabled
  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      bus_if.ready_i = (ph == 0);
      ph = (ph + 1) % 3;
    end else begin
      bus_if.ready_i = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check_eq("hold_valid", bus_if.valid_o, 1);
        check_eq("hold_data", bus_if.data_o, prev_d);
      end
      if (bus_if.valid_o) begin
        check_eq("busy_with_valid", bus_if.busy, 1);
        if (bus_if.ready_i) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_output", bus_if.valid_o, 0);
          end else begin
            check_eq("data", bus_if.data_o, exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end else begin
        check_eq("zero_when_idle", bus_if.data_o, 0);
      end
      stall_prev = bus_if.valid_o && !bus_if.ready_i;
      prev_d     = bus_if.data_o;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send_byte(input logic [7:0] c, input bit mode, input int kn, input int km);
    bus_if.data_i  = c;
    bus_if.valid_i = 1'b1;
    bus_if.mode_i  = mode;
    bus_if.key_N   = 8'(kn);
    bus_if.key_M   = 8'(km);
    @(posedge clk);
    #1;
    bus_if.valid_i = 1'b0;
    bus_if.data_i  = '0;
  endtask

  task automatic load_msg(input string tag, input string s, input int kn, input int km,
                          input bit mode, input bit ok);
    logic [7:0] b[$];
    for (int i = 0; i < s.len(); i++) begin
      b.push_back(s[i]);
      send_byte(s[i], 1'b0, 0, 0);
    end
    if (ok) begin
      if (!mode) begin
        for (int j = 0; j < kn; j++)
          for (int k = 0; k < km; k++) exp_q.push_back(b[j + k * kn]);
      end else begin
        for (int k = 0; k < km; k++)
          for (int j = 0; j < kn; j++) exp_q.push_back(b[k + j * km]);
      end
    end
    send_byte(8'hFA, mode, kn, km);
    @(negedge clk);
    check_eq({tag, "_latency_valid"}, bus_if.valid_o, 32'(ok));
    check_eq({tag, "_err_pulse"}, bus_if.err_o, 32'(!ok));
    check_eq({tag, "_busy_start"}, bus_if.busy, 32'(ok));
  endtask

  task automatic finish_msg(input string tag, input bit junk);
    bit done = 0;
    if (junk) begin
      bus_if.data_i  = 8'h51;
      bus_if.valid_i = 1'b1;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #2;
      done = (exp_q.size() == 0) && !bus_if.valid_o;
    end
    bus_if.valid_i = 1'b0;
    bus_if.data_i  = '0;
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_busy_end"}, bus_if.busy, 0);
    check_eq({tag, "_err_end"}, bus_if.err_o, 0);
  endtask

  task automatic run_msg(input string tag, input string s, input int kn, input int km,
                         input bit mode, input bit ok, input bit junk);
    load_msg(tag, s, kn, km, mode, ok);
    finish_msg(tag, junk);
  endtask

  initial begin
    string s64;
    string s65;
    bit done;
    int x0;
    bus_if.data_i  = '0;
    bus_if.valid_i = 1'b0;
    bus_if.mode_i  = 1'b0;
    bus_if.key_N   = '0;
    bus_if.key_M   = '0;
    s64 = "";
    for (int i = 0; i < 64; i++) s64 = $sformatf("%s%c", s64, 8'(33 + i));
    s65 = {s64, "z"};

    #12;
    check_eq("reset_valid", bus_if.valid_o, 0);
    check_eq("reset_busy", bus_if.busy, 0);
    check_eq("reset_err", bus_if.err_o, 0);
    check_eq("reset_data", bus_if.data_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_msg("dec23", "ABCDEF", 2, 3, 1'b0, 1'b1, 1'b0);
    run_msg("enc23", "ACEBDF", 2, 3, 1'b1, 1'b1, 1'b0);
    bp_en = 1;
    run_msg("bp_dec23", "ABCDEF", 2, 3, 1'b0, 1'b1, 1'b0);
    bp_en = 0;
    run_msg("junk_dec34", "HELLOWORLD!?", 3, 4, 1'b0, 1'b1, 1'b1);
    run_msg("after_junk", "ABCDEF", 2, 3, 1'b0, 1'b1, 1'b0);
    run_msg("err_short", "ABCDE", 2, 3, 1'b0, 1'b0, 1'b0);
    run_msg("err_n0", "ABC", 0, 3, 1'b0, 1'b0, 1'b0);
    run_msg("err_ovf", s65, 8, 8, 1'b0, 1'b0, 1'b0);
    run_msg("full_dec88", s64, 8, 8, 1'b0, 1'b1, 1'b0);
    run_msg("enc42", "abcdefgh", 4, 2, 1'b1, 1'b1, 1'b0);

    load_msg("rst_mid", "ABCDEF", 2, 3, 1'b0, 1'b1);
    x0   = xfer_cnt;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk);
      #2;
      done = (xfer_cnt - x0) >= 2;
    end
    check_eq("rst_mid_two_out", 32'(done), 1);
    check_eq("rst_mid_pre_valid", bus_if.valid_o, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", bus_if.valid_o, 0);
    check_eq("rst_mid_busy", bus_if.busy, 0);
    check_eq("rst_mid_data", bus_if.data_o, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_msg("post_rst_dec22", "WXYZ", 2, 2, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
